// File: rtl/uart_pkg.sv
// UART receive shared types: frame width, parity mode codes, stored RX entry.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package uart_pkg;

   localparam int FRAME_W = 11;

   localparam logic [1:0] PARITY_NONE = 2'b00;
   localparam logic [1:0] PARITY_EVEN = 2'b01;
   localparam logic [1:0] PARITY_ODD  = 2'b10;

   // One received character plus its line-error flags.
   typedef struct packed {
      logic       brk;
      logic       fe;
      logic       pe;
      logic [7:0] data;
   } rx_entry_t;

endpackage

// File: rtl/rx_backend_if.sv
// Read port between the RX FIFO and the register layer (valid/ready).
// Latency: none (wires only).
// Backpressure: the reader holds rx_ready_i low to keep the head entry.
interface rx_backend_if;
   logic [7:0] rx_data_o;
   logic       rx_pe_o;
   logic       rx_fe_o;
   logic       rx_brk_o;
   logic       rx_valid_o;
   logic       rx_ready_i;

   modport master (output rx_data_o, rx_pe_o, rx_fe_o, rx_brk_o, rx_valid_o,
                   input  rx_ready_i);
   modport slave  (input  rx_data_o, rx_pe_o, rx_fe_o, rx_brk_o, rx_valid_o,
                   output rx_ready_i);
endinterface

// File: rtl/rx_backend_sync_fifo.sv
// Generic single-clock FIFO with separate level counter and combinational head.
// Latency: a push is visible at the head one cycle later when empty.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           wdata_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic                       empty_o,
   output logic                       full_o,
   output logic [$clog2(DEPTH):0]     level_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q,  level_d;
   logic             push_ok, pop_ok;

   assign empty_o = (level_q == '0);
   assign full_o  = (level_q == LW'(DEPTH));
   assign level_o = level_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // A pop frees a slot in the same cycle, so a full FIFO still takes a push alongside it.
   always_comb begin
      pop_ok   = pop_i & ~empty_o;
      push_ok  = push_i & (~full_o | pop_ok);
      wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      level_d  = level_q;
      if (push_ok && !pop_ok) level_d = level_q + 1'b1;
      if (!push_ok && pop_ok) level_d = level_q - 1'b1;
   end

   // Pointer and level registers.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage is cleared on reset so the head reads zero while empty.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push_ok) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end
endmodule

// File: rtl/rx_backend.sv
// UART RX back end: decodes a completed frame word and queues {brk,fe,pe,data}.
// Latency: frame pulse at T -> entry at FIFO head (rx_valid_o) at T+1 when empty.
// Backpressure: reader stalls via rx_ready_i; frames arriving while full are dropped and flag overrun.
module rx_backend
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [FRAME_W-1:0]            frame_data_i,
   input  logic                          frame_valid_i,
   input  logic                          cr_ds_i,
   input  logic [1:0]                    cr_p_i,
   input  logic                          cr_s_i,
   rx_backend_if.master                  rx,
   output logic [$clog2(FIFO_DEPTH):0]   level_o,
   output logic                          full_o,
   output logic                          overrun_o,
   input  logic                          overrun_clr_i
);
   rx_entry_t  dec_entry;
   rx_entry_t  head_entry;
   logic [3:0] nd;
   logic [3:0] p_off;
   logic [3:0] p_off2;
   logic       has_par;
   logic       par_bit;
   logic       stop1;
   logic       stop2;
   logic       fifo_empty;
   logic       pop;
   logic       drop;
   logic       overrun_q, overrun_d;

   // Frame decode with the configuration seen in the strobe cycle.
   always_comb begin
      has_par   = (cr_p_i != PARITY_NONE);
      nd        = cr_ds_i ? 4'd8 : 4'd7;
      p_off     = nd + {3'b000, has_par};
      p_off2    = p_off + 4'd1;
      par_bit   = frame_data_i[nd];
      stop1     = frame_data_i[p_off];
      stop2     = frame_data_i[p_off2];
      dec_entry = '0;
      dec_entry.data = cr_ds_i ? frame_data_i[7:0] : {1'b0, frame_data_i[6:0]};
      case (cr_p_i)
         PARITY_NONE: dec_entry.pe = 1'b0;
         PARITY_EVEN: dec_entry.pe =  (^dec_entry.data ^ par_bit);
         default:     dec_entry.pe = ~(^dec_entry.data ^ par_bit); // reserved code behaves as odd
      endcase
      dec_entry.fe  = ~stop1 | (cr_s_i & ~stop2);
      dec_entry.brk = (dec_entry.data == 8'h00) & ~(has_par & par_bit) & ~stop1;
   end

   assign pop  = rx.rx_valid_o & rx.rx_ready_i;
   assign drop = frame_valid_i & full_o & ~pop;

   sync_fifo #(
      .WIDTH ($bits(rx_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (frame_valid_i),
      .wdata_i (dec_entry),
      .pop_i   (rx.rx_ready_i),
      .rdata_o (head_entry),
      .empty_o (fifo_empty),
      .full_o  (full_o),
      .level_o (level_o)
   );

   assign rx.rx_valid_o = ~fifo_empty;
   assign rx.rx_data_o  = head_entry.data;
   assign rx.rx_pe_o    = head_entry.pe;
   assign rx.rx_fe_o    = head_entry.fe;
   assign rx.rx_brk_o   = head_entry.brk;
   assign overrun_o     = overrun_q;

   // Sticky overrun: a new drop takes priority over a clear in the same cycle.
   always_comb begin
      overrun_d = overrun_q;
      if (overrun_clr_i) overrun_d = 1'b0;
      if (drop)          overrun_d = 1'b1;
   end

   // Overrun flag register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) overrun_q <= 1'b0;
      else        overrun_q <= overrun_d;
   end
endmodule

// File: tb/tb_rx_backend.sv
module tb_rx_backend;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [10:0] frame_data = '0;
   logic        frame_valid = 1'b0;
   logic        cr_ds = 1'b1;
   logic [1:0]  cr_p = 2'b00;
   logic        cr_s = 1'b0;
   logic        overrun_clr = 1'b0;
   logic [3:0]  level;
   logic        full;
   logic        overrun;

   int n_checks = 0;
   int n_fail   = 0;
   int mlevel   = 0;
   logic [10:0] sb_q[$];

   rx_backend_if rxif ();

   always #5 clk = ~clk;

   rx_backend #(.FIFO_DEPTH(DEPTH)) dut (
      .clk_i         (clk),
      .rst_i         (rst_n),
      .frame_data_i  (frame_data),
      .frame_valid_i (frame_valid),
      .cr_ds_i       (cr_ds),
      .cr_p_i        (cr_p),
      .cr_s_i        (cr_s),
      .rx            (rxif),
      .level_o       (level),
      .full_o        (full),
      .overrun_o     (overrun),
      .overrun_clr_i (overrun_clr)
   );

   function automatic logic [10:0] head();
      return {rxif.rx_brk_o, rxif.rx_fe_o, rxif.rx_pe_o, rxif.rx_data_o};
   endfunction

   // Reference decode written bit-by-bit from the frame layout.
   function automatic logic [10:0] model(input logic [10:0] fd, input logic ds,
                                          input logic [1:0] p, input logic s);
      int nd = ds ? 8 : 7;
      int pos;
      logic [7:0] d = '0;
      logic x = 1'b0, allz = 1'b1, pe = 1'b0, fe, brk;
      for (int i = 0; i < nd; i++) begin
         d[i] = fd[i];
         x ^= fd[i];
         if (fd[i]) allz = 1'b0;
      end
      pos = nd;
      if (p != 2'b00) begin
         x ^= fd[pos];
         if (fd[pos]) allz = 1'b0;
         pe = (p == 2'b01) ? x : ~x;
         pos++;
      end
      fe  = ~fd[pos] | (s & ~fd[pos+1]);
      brk = allz & ~fd[pos];
      return {brk, fe, pe, d};
   endfunction

   // Stimulus only: one-cycle frame strobe, scoreboard updated if the frame fits.
   task automatic drive_frame(input logic [10:0] fd);
      frame_data  = fd;
      frame_valid = 1'b1;
      if (mlevel < DEPTH) begin
         sb_q.push_back(model(fd, cr_ds, cr_p, cr_s));
         mlevel++;
      end
      @(negedge clk);
      frame_valid = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++;
      if ({level, full, overrun, rxif.rx_valid_o} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got level=%0d full=%b ovr=%b valid=%b, need all 0",
                  level, full, overrun, rxif.rx_valid_o);
      end
      n_checks++;
      if (head() !== 11'h000) begin
         n_fail++;
         $display("FAIL reset_head: got %h need 000", head());
      end
   endtask

   task automatic test_8n1();
      cr_ds = 1'b1; cr_p = 2'b00; cr_s = 1'b0;
      drive_frame(11'h1A5);
      n_checks++;
      if (!(rxif.rx_valid_o === 1'b1 && head() === 11'h0A5 && level === 4'd1)) begin
         n_fail++;
         $display("FAIL 8n1_head: valid=%b head=%h level=%0d need 1 0a5 1",
                  rxif.rx_valid_o, head(), level);
      end
      rxif.rx_ready_i = 1'b1;
      @(negedge clk);
      rxif.rx_ready_i = 1'b0;
      void'(sb_q.pop_front()); mlevel--;
      n_checks++;
      if (rxif.rx_valid_o !== 1'b0 || level !== 4'd0) begin
         n_fail++;
         $display("FAIL 8n1_pop: valid=%b level=%0d need 0 0", rxif.rx_valid_o, level);
      end
   endtask

   task automatic test_8e1();
      cr_ds = 1'b1; cr_p = 2'b01; cr_s = 1'b0;
      drive_frame(11'h2A5);
      drive_frame(11'h3A5);
      n_checks++;
      if (head() !== 11'h0A5 || level !== 4'd2) begin
         n_fail++;
         $display("FAIL 8e1_first: head=%h level=%0d need 0a5 2", head(), level);
      end
      while (sb_q.size() > 0) begin
         n_checks++;
         if (rxif.rx_valid_o !== 1'b1 || head() !== sb_q[0]) begin
            n_fail++;
            $display("FAIL 8e1_drain: valid=%b head=%h need 1 %h", rxif.rx_valid_o, head(), sb_q[0]);
         end
         if (sb_q.size() == 1) begin
            n_checks++;
            if (head() !== 11'h1A5) begin
               n_fail++;
               $display("FAIL 8e1_second: head=%h need 1a5", head());
            end
         end
         rxif.rx_ready_i = 1'b1;
         @(negedge clk);
         rxif.rx_ready_i = 1'b0;
         void'(sb_q.pop_front()); mlevel--;
      end
   endtask

   task automatic test_7o2();
      cr_ds = 1'b0; cr_p = 2'b10; cr_s = 1'b1;
      drive_frame(11'h3C1);
      drive_frame(11'h1C1);
      n_checks++;
      if (head() !== 11'h041) begin
         n_fail++;
         $display("FAIL 7o2_ok: head=%h need 041", head());
      end
      rxif.rx_ready_i = 1'b1;
      @(negedge clk);
      rxif.rx_ready_i = 1'b0;
      void'(sb_q.pop_front()); mlevel--;
      n_checks++;
      if (head() !== 11'h241 || head() !== sb_q[0]) begin
         n_fail++;
         $display("FAIL 7o2_fe: head=%h need 241", head());
      end
      rxif.rx_ready_i = 1'b1;
      @(negedge clk);
      rxif.rx_ready_i = 1'b0;
      void'(sb_q.pop_front()); mlevel--;
   endtask

   task automatic test_break();
      cr_ds = 1'b1; cr_p = 2'b00; cr_s = 1'b0;
      drive_frame(11'h000);
      n_checks++;
      if (head() !== 11'h600 || head() !== sb_q[0]) begin
         n_fail++;
         $display("FAIL break: head=%h need 600", head());
      end
      rxif.rx_ready_i = 1'b1;
      @(negedge clk);
      rxif.rx_ready_i = 1'b0;
      void'(sb_q.pop_front()); mlevel--;
   endtask

   task automatic test_overrun();
      cr_ds = 1'b1; cr_p = 2'b00; cr_s = 1'b0;
      for (int i = 1; i <= 8; i++) drive_frame(11'h100 + 11'(i));
      n_checks++;
      if (full !== 1'b1 || overrun !== 1'b0 || level !== 4'd8) begin
         n_fail++;
         $display("FAIL ovr_fill: full=%b ovr=%b level=%0d need 1 0 8", full, overrun, level);
      end
      drive_frame(11'h109);
      n_checks++;
      if (full !== 1'b1 || overrun !== 1'b1 || level !== 4'd8) begin
         n_fail++;
         $display("FAIL ovr_set: full=%b ovr=%b level=%0d need 1 1 8", full, overrun, level);
      end
      for (int i = 1; i <= 8; i++) begin
         n_checks++;
         if (rxif.rx_valid_o !== 1'b1 || rxif.rx_data_o !== 8'(i) || head() !== sb_q[0]) begin
            n_fail++;
            $display("FAIL ovr_drain%0d: valid=%b head=%h need data %h", i, rxif.rx_valid_o, head(), 8'(i));
         end
         rxif.rx_ready_i = 1'b1;
         @(negedge clk);
         rxif.rx_ready_i = 1'b0;
         void'(sb_q.pop_front()); mlevel--;
      end
      n_checks++;
      if (rxif.rx_valid_o !== 1'b0 || overrun !== 1'b1) begin
         n_fail++;
         $display("FAIL ovr_sticky: valid=%b ovr=%b need 0 1", rxif.rx_valid_o, overrun);
      end
      overrun_clr = 1'b1;
      @(negedge clk);
      overrun_clr = 1'b0;
      n_checks++;
      if (overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL ovr_clr: ovr=%b need 0", overrun);
      end
   endtask

   task automatic test_full_push_pop();
      cr_ds = 1'b1; cr_p = 2'b00; cr_s = 1'b0;
      for (int i = 0; i < 8; i++) drive_frame(11'h110 + 11'(i));
      // push and pop together while full
      frame_data = 11'h1EE; frame_valid = 1'b1; rxif.rx_ready_i = 1'b1;
      void'(sb_q.pop_front());
      sb_q.push_back(model(11'h1EE, cr_ds, cr_p, cr_s));
      @(negedge clk);
      frame_valid = 1'b0; rxif.rx_ready_i = 1'b0;
      n_checks++;
      if (level !== 4'd8 || full !== 1'b1 || overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL pp_full: level=%0d full=%b ovr=%b need 8 1 0", level, full, overrun);
      end
      // drop coinciding with clear: set wins, contents untouched
      overrun_clr = 1'b1;
      drive_frame(11'h1FF);
      overrun_clr = 1'b0;
      n_checks++;
      if (overrun !== 1'b1 || level !== 4'd8) begin
         n_fail++;
         $display("FAIL set_wins: ovr=%b level=%0d need 1 8", overrun, level);
      end
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (rxif.rx_valid_o !== 1'b1 || head() !== sb_q[0]) begin
            n_fail++;
            $display("FAIL pp_order%0d: valid=%b head=%h need %h", i, rxif.rx_valid_o, head(), sb_q[0]);
         end
         rxif.rx_ready_i = 1'b1;
         @(negedge clk);
         rxif.rx_ready_i = 1'b0;
         void'(sb_q.pop_front()); mlevel--;
      end
      // ready while empty is ignored
      rxif.rx_ready_i = 1'b1;
      @(negedge clk);
      rxif.rx_ready_i = 1'b0;
      n_checks++;
      if (level !== 4'd0 || rxif.rx_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL empty_pop: level=%0d valid=%b need 0 0", level, rxif.rx_valid_o);
      end
      overrun_clr = 1'b1;
      @(negedge clk);
      overrun_clr = 1'b0;
   endtask

   task automatic test_reset_mid_drain();
      cr_ds = 1'b1; cr_p = 2'b00; cr_s = 1'b0;
      for (int i = 0; i < 4; i++) drive_frame(11'h130 + 11'(i));
      rxif.rx_ready_i = 1'b1;
      @(negedge clk);
      void'(sb_q.pop_front()); mlevel--;
      #2 rst_n = 1'b0;
      #1;
      rxif.rx_ready_i = 1'b0;
      sb_q.delete(); mlevel = 0;
      n_checks++;
      if (level !== 4'd0 || rxif.rx_valid_o !== 1'b0 || full !== 1'b0 || head() !== 11'h000) begin
         n_fail++;
         $display("FAIL rst_mid: level=%0d valid=%b full=%b head=%h need 0 0 0 000",
                  level, rxif.rx_valid_o, full, head());
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      drive_frame(11'h15A);
      n_checks++;
      if (level !== 4'd1 || head() !== 11'h05A || head() !== sb_q[0]) begin
         n_fail++;
         $display("FAIL rst_resume: level=%0d head=%h need 1 05a", level, head());
      end
      rxif.rx_ready_i = 1'b1;
      @(negedge clk);
      rxif.rx_ready_i = 1'b0;
      void'(sb_q.pop_front()); mlevel--;
   endtask

   initial begin
      rxif.rx_ready_i = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_8n1();
      test_8e1();
      test_7o2();
      test_break();
      test_overrun();
      test_full_push_pop();
      test_reset_mid_drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded 200000 time units, need completion");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/rx_backend.md
Name: rx_backend

Overview:
- Sits directly downstream of the UART receive front end. Each time the front end flags a completed frame, this block consumes the aligned frame word.
- Decodes the frame word according to the current data-size / parity / stop configuration: extracts the 7/8 data bits and checks parity, stop bits and break.
- Stores {data, error flags} in a small FIFO that the Wishbone register layer reads through a valid/ready handshake. Reports fill level, full and a sticky overrun flag.

Parameters:
- FIFO_DEPTH, 8, number of stored frames; must be a power of two, ≥ 2.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  asynchronous reset, active-low
- frame_data_i  input  11  aligned frame word from the front end; bit0 = first data bit, then optional parity bit, then stop bit(s); unused upper bits ignored
- frame_valid_i  input  1  one-cycle pulse: frame_data_i is complete
- cr_ds_i  input  1  0 = 7 data bits, 1 = 8 data bits
- cr_p_i  input  2  parity mode: 00 none, 01 even, 10 odd, 11 reserved (treated as odd)
- cr_s_i  input  1  0 = 1 stop bit, 1 = 2 stop bits
- rx_data_o  output  8  head-of-FIFO data; bit7 = 0 in 7-bit mode
- rx_pe_o  output  1  head-of-FIFO parity error
- rx_fe_o  output  1  head-of-FIFO framing error
- rx_brk_o  output  1  head-of-FIFO break condition
- rx_valid_o  output  1  FIFO not empty
- rx_ready_i  input  1  pop head when rx_valid_o = 1
- level_o  output  $clog2(FIFO_DEPTH)+1  number of stored frames
- full_o  output  1  level_o == FIFO_DEPTH
- overrun_o  output  1  sticky: a frame was dropped because the FIFO was full
- overrun_clr_i  input  1  clears overrun_o

Behaviour:
- Reset (asynchronous, rst_i = 0): FIFO pointers = 0, level_o = 0, rx_valid_o = 0, full_o = 0, overrun_o = 0, rx_data_o/rx_pe_o/rx_fe_o/rx_brk_o = 0. Reset mid-frame or mid-read discards all contents; there is no partial state to recover.
- Decode is combinational and uses the configuration present in the cycle frame_valid_i is high.
  - nd = 7 + cr_ds_i.
  - Data = frame_data_i[nd-1:0], zero-extended to 8 bits.
  - Parity bit index = nd. Stop bits start at p_off = nd + (cr_p_i != 0).
  - pe: cr_p_i == 00 → 0. Even mode → XOR(data bits, parity bit) == 1. Odd mode → XOR(data bits, parity bit) == 0.
  - fe: frame_data_i[p_off] == 0, or (cr_s_i && frame_data_i[p_off+1] == 0).
  - brk: all data bits = 0, parity bit = 0 (if present), and first stop bit = 0. brk implies fe.
- Push:
  - On frame_valid_i & (!full_o | pop), the entry {brk, fe, pe, data} is written at the clock edge.
  - Visible at the head one cycle later if the FIFO was empty, so rx_valid_o rises at T+1 for a pulse at T.
- Pop: rx_valid_o & rx_ready_i at an edge advances the read pointer. rx_ready_i while empty is ignored.
- Simultaneous push and pop:
  - Level is unchanged and both are accepted, including when full.
  - When empty, a push and a pop cannot coincide, since no pop is possible.
- Overrun:
  - frame_valid_i while full with no pop: the frame is dropped, FIFO contents are unchanged, and overrun_o is set the next cycle.
  - overrun_o stays high until overrun_clr_i.
  - If overrun_clr_i and a new overrun occur in the same cycle, set wins.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. level_o is a separate counter (+1 push, −1 pop, 0 net on both).
- Outputs rx_* are driven straight from head storage; there is no output register stage.

Decomposition:
- Package uart_pkg:
  - parity mode constants PARITY_NONE / EVEN / ODD.
  - rx_entry_t packed struct {brk, fe, pe, data[7:0]}.
  - FRAME_W = 11.
- One sub-module, sync_fifo, parameterised on width and depth: storage, pointers, level, full/empty. rx_backend holds the decode logic, overrun logic and FIFO instance.

Test Plan:
- 8N1 (ds=1, p=00, s=0): frame 0x1A5 pulse → next cycle rx_valid_o = 1, rx_data_o = 0xA5, pe = fe = brk = 0, level_o = 1. Then ready → rx_valid_o = 0.
- 8E1: frame 0x2A5 → pe = 0. Frame 0x3A5 → pe = 1, fe = 0. Both are queued in order.
- 7O2 (ds=0, p=10, s=1): frame 0x3C1 → rx_data_o = 0x41, pe = 0, fe = 0. Frame 0x1C1 (second stop = 0) → fe = 1.
- 8N1 frame 0x000 → rx_data_o = 0x00, fe = 1, brk = 1.
- Overrun, FIFO_DEPTH = 8, no ready:
  - push frames 0x101..0x109 (8N1) → level_o = 8, full_o = 1, overrun_o = 1.
  - Draining returns data 0x01..0x08.
  - overrun_clr_i → overrun_o = 0.
- Full FIFO, push and pop in the same cycle → level_o stays 8, overrun_o stays 0, and the new frame appears after the 7 older ones. Asserting rst_i low mid-drain → level_o = 0, rx_valid_o = 0 immediately.
